// File: rtl/rtl_seq_pkg.sv
// Shared definitions for the sequenced arithmetic controllers (multiplier now,
// divider/shift controllers later): state encodings and iteration-counter sizing.
package rtl_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Counter must hold the iteration count itself after the final step.
    function automatic int cnt_w(input int iters);
        return (iters < 1) ? 1 : $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/rtl_seq_mul_dp.sv
// Shift-and-add datapath: multiplicand register, partial-product/multiplier
// register P, one SIZE1-bit adder with carry-out, and a one-bit right shift.
module rtl_seq_mul_dp #(
    parameter int SIZE1 = 4,
    parameter int SIZE2 = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic [SIZE1-1:0]       mcand_i,
    input  logic [SIZE2-1:0]       mplier_i,
    output logic [SIZE1+SIZE2-1:0] p_nxt_o
);

    localparam int PW = SIZE1 + SIZE2;

    logic [SIZE1-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    p_q, p_d, p_shift;
    logic [SIZE1:0]   sum;

    assign sum = {1'b0, p_q[PW-1:SIZE2]} + {1'b0, mcand_q};

    // The carry lands in the top bit of the shifted word; with a single
    // multiplier bit there are no lower bits left to shift in.
    generate
        if (SIZE2 == 1) begin : g_one_bit
            assign p_shift = p_q[0] ? sum : (p_q >> 1);
        end else begin : g_multi_bit
            assign p_shift = p_q[0] ? {sum, p_q[SIZE2-1:1]} : (p_q >> 1);
        end
    endgenerate

    always_comb begin
        mcand_d = mcand_q;
        p_d     = p_q;
        if (load_i) begin
            mcand_d = mcand_i;
            p_d     = {{SIZE1{1'b0}}, mplier_i};
        end else if (step_i) begin
            p_d     = p_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            p_q     <= '0;
        end else begin
            mcand_q <= mcand_d;
            p_q     <= p_d;
        end
    end

    assign p_nxt_o = p_d;

endmodule

// File: rtl/rtl_seq_mul_ctrl.sv
// Sequenced unsigned multiplier: start/busy/done controller driving a shared
// shift-and-add datapath for SIZE2 iterations per product.
module rtl_seq_mul_ctrl
    import rtl_seq_pkg::*;
#(
    parameter int SIZE1 = 4,
    parameter int SIZE2 = 4,
    parameter int AREA  = SIZE1 * 3,
    parameter int DELAY = SIZE2 + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SIZE1-1:0]       in1,
    input  logic [SIZE2-1:0]       in2,
    output logic                   busy,
    output logic                   done,
    output logic [SIZE1+SIZE2-1:0] out
);

    localparam int CW = cnt_w(SIZE2);
    localparam int PW = SIZE1 + SIZE2;

    // AREA and DELAY only guide the mapper; reject nonsensical values early.
    generate
        if (SIZE1 < 1 || SIZE2 < 1 || AREA < 0 || DELAY < 0) begin : g_param_chk
            $error("rtl_seq_mul_ctrl: invalid parameter set");
        end
    endgenerate

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  out_q, out_d;
    logic [PW-1:0]  p_nxt;
    logic           load, step, last;

    assign last = (cnt_q == CW'(SIZE2 - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        step = (state_q == ST_RUN);
        load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load)      cnt_d = '0;
        else if (step) cnt_d = cnt_q + CW'(1);
    end

    // The product is captured from the datapath's next value so it is valid
    // for the whole DONE cycle and frozen until the next result.
    always_comb begin
        out_d = out_q;
        if (step && last) out_d = p_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

    rtl_seq_mul_dp #(
        .SIZE1 (SIZE1),
        .SIZE2 (SIZE2)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (in1),
        .mplier_i (in2),
        .p_nxt_o  (p_nxt)
    );

endmodule

// File: tb/tb_rtl_seq_mul_ctrl.sv
// Bench for rtl_seq_mul_ctrl: directed handshake cases plus random operations
// on a 4x4 and an 8x1 instance, checked against in1*in2 and the cycle budget.
module tb_rtl_seq_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset_a = 1'b0, start_a = 1'b0, busy_a, done_a;
    logic [3:0]  in1_a = '0, in2_a = '0;
    logic [7:0]  out_a;
    logic        reset_b = 1'b0, start_b = 1'b0, busy_b, done_b;
    logic [7:0]  in1_b = '0;
    logic [0:0]  in2_b = '0;
    logic [8:0]  out_b;

    int n_chk = 0;
    int n_bad = 0;
    int prev_a = 0;
    int prev_b = 0;

    always #5 clk = ~clk;

    rtl_seq_mul_ctrl #(.SIZE1(4), .SIZE2(4)) u_dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .in1(in1_a), .in2(in2_a),
        .busy(busy_a), .done(done_a), .out(out_a)
    );

    rtl_seq_mul_ctrl #(.SIZE1(8), .SIZE2(1)) u_dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .in1(in1_b), .in2(in2_b),
        .busy(busy_b), .done(done_b), .out(out_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic [31:0] get_out(input bit sel);
        return sel ? {23'd0, out_b} : {24'd0, out_a};
    endfunction

    // One operation: start pulsed for a single cycle, then the result must
    // appear exactly iters+1 sampling points later with busy high iters times.
    task automatic do_op(input bit sel, input int a, input int b);
        int lat, nbusy, iters, prev;
        iters = sel ? 1 : 4;
        prev  = sel ? prev_b : prev_a;
        @(negedge clk);
        if (sel) begin in1_b = 8'(a); in2_b = 1'(b); start_b = 1'b1; end
        else     begin in1_a = 4'(a); in2_a = 4'(b); start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) nbusy++;
            chk("out_hold", get_out(sel), prev);
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'd0, get_done(sel)}, 32'd1);
        chk("latency", lat, iters + 1);
        chk("busy_cycles", nbusy, iters);
        chk("busy_in_done", {31'd0, get_busy(sel)}, 32'd0);
        chk("product", get_out(sel), a * b);
        if (sel) prev_b = a * b;
        else     prev_a = a * b;
    endtask

    initial begin
        int lat, a, b;

        // Reset state
        #1;
        reset_a = 1'b1;
        reset_b = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_out", {24'd0, out_a}, 32'd0);
        chk("rst_out_b", {23'd0, out_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Basic products, carry path, zero operand
        do_op(1'b0, 3, 5);
        @(negedge clk);
        chk("done_pulse_1cyc", {31'd0, done_a}, 32'd0);
        chk("out_after_done", {24'd0, out_a}, 32'd15);
        do_op(1'b0, 15, 15);
        do_op(1'b0, 0, 9);

        // start held through RUN: ignored there, accepted again in DONE
        @(negedge clk);
        in1_a = 4'd6; in2_a = 4'd7; start_a = 1'b1;
        @(negedge clk);
        in1_a = 4'd2; in2_a = 4'd5;
        lat = 1;
        while (!done_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_latency", lat, 5);
        chk("hold_product", {24'd0, out_a}, 32'd42);
        @(negedge clk);
        chk("b2b_busy", {31'd0, busy_a}, 32'd1);
        chk("b2b_out_held", {24'd0, out_a}, 32'd42);
        start_a = 1'b0;
        lat = 1;
        while (!done_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", lat, 5);
        chk("b2b_product", {24'd0, out_a}, 32'd10);
        prev_a = 10;

        // Reset in the second RUN cycle discards the operation
        @(negedge clk);
        in1_a = 4'd9; in2_a = 4'd9; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        chk("mid_busy_before", {31'd0, busy_a}, 32'd1);
        reset_a = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        chk("mid_rst_out", {24'd0, out_a}, 32'd0);
        @(negedge clk);
        reset_a = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_a || busy_a) lat++;
        end
        chk("no_done_after_rst", lat, 0);
        prev_a = 0;
        do_op(1'b0, 2, 3);

        // Single-iteration instance
        do_op(1'b1, 200, 1);
        do_op(1'b1, 200, 0);
        do_op(1'b1, 255, 1);

        // Random scoreboard
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            do_op(1'b0, a, b);
        end
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 1));
            do_op(1'b1, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
